// File: rtl/bit_serial_adder_32.sv
// Bit-serial 32-bit adder: one bit per clock, LSB first, with registered
// sum, carry-out and two's-complement overflow. A full operation takes
// 34 cycles from accepting start to being able to accept the next one.
module bit_serial_adder_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  output logic [31:0] S,
  output logic        Cout,
  output logic        Ovf,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e      state_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] res_q;
  logic        carry_q;
  logic [4:0]  cnt_q;

  logic        sum_bit;
  logic        carry_nxt;

  // One full-adder slice operating on the current LSBs of the operand registers.
  always_comb begin
    sum_bit   = a_q[0] ^ b_q[0] ^ carry_q;
    carry_nxt = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
  end

  // FSM, datapath shift registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      S       <= '0;
      Cout    <= 1'b0;
      Ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= A;
            b_q     <= B;
            carry_q <= Cin;
            res_q   <= '0;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Sum bits enter at the MSB so that after 32 shifts bit 0 sits at res[0].
          res_q   <= {sum_bit, res_q[31:1]};
          a_q     <= {1'b0, a_q[31:1]};
          b_q     <= {1'b0, b_q[31:1]};
          carry_q <= carry_nxt;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) begin
            S       <= {sum_bit, res_q[31:1]};
            Cout    <= carry_nxt;
            // carry_q here is the carry into bit 31.
            Ovf     <= carry_q ^ carry_nxt;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder_32.sv
// Self-checking bench for bit_serial_adder_32: directed table, random
// operations against an arithmetic model, and multi-cycle corner sequences.
module tb_bit_serial_adder_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic [31:0] S;
  logic        Cout;
  logic        Ovf;
  logic        busy;
  logic        done;

  int n_vec;
  int n_miss;

  bit_serial_adder_32 dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
    .S    (S),
    .Cout (Cout),
    .Ovf  (Ovf),
    .busy (busy),
    .done (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 33-bit addition; overflow from operand/result signs.
  task automatic ref_model(input logic [31:0] a, input logic [31:0] b, input logic cin,
                           output logic [31:0] s, output logic cout, output logic ovf);
    logic [32:0] sum;
    sum  = {1'b0, a} + {1'b0, b} + {32'd0, cin};
    s    = sum[31:0];
    cout = sum[32];
    ovf  = (a[31] == b[31]) && (sum[31] != a[31]);
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic cin, input logic [31:0] es, input logic ec,
                        input logic eo);
    int cyc;
    bit busy_ok;
    A = a;
    B = b;
    Cin = cin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
      cyc++;
    end
    if (busy !== 1'b1) busy_ok = 1'b0;
    chk({tag, "_latency"}, 64'(cyc), 64'd32);
    chk({tag, "_busy"}, 64'(busy_ok), 64'd1);
    chk({tag, "_S"}, 64'(S), 64'(es));
    chk({tag, "_Cout"}, 64'(Cout), 64'(ec));
    chk({tag, "_Ovf"}, 64'(Ovf), 64'(eo));
    @(negedge clk);
    chk({tag, "_idle"}, 64'({busy, done}), 64'd0);
  endtask

  initial begin
    vec_t        tbl[8];
    logic [31:0] rs;
    logic        rc;
    logic        ro;
    logic [31:0] ha[0:110];
    logic [31:0] hb[0:110];
    logic        hc[0:110];
    int          pulses;
    int          last_t;
    int          done_cyc;

    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    Cin = 1'b0;

    tbl[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0};
    tbl[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    tbl[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[4] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[7] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_S", 64'(S), 64'd0);
    chk("reset_flags", 64'({Cout, Ovf, busy, done}), 64'd0);
    rst = 1'b0;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("tbl%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
             tbl[i].s, tbl[i].cout, tbl[i].ovf);
    end

    // Result holds through idle
    repeat (5) @(negedge clk);
    chk("idle_hold_S", 64'(S), 64'(tbl[7].s));
    chk("idle_hold_flags", 64'({Cout, Ovf, busy, done}), 64'(4'b0100));

    // Random operations
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rci;
      ra = $urandom;
      rb = $urandom;
      rci = 1'($urandom);
      if (i % 4 == 0) rb = ~ra;
      ref_model(ra, rb, rci, rs, rc, ro);
      run_op($sformatf("rnd%0d", i), ra, rb, rci, rs, rc, ro);
    end

    // Start and operand changes during RUN are ignored
    A = 32'h0000_0010;
    B = 32'h0000_0020;
    Cin = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    done_cyc = -1;
    for (int t = 0; t < 70; t++) begin
      if (t == 10) begin
        start = 1'b1;
        A = 32'hFFFF_FFFF;
        B = 32'hFFFF_FFFF;
        Cin = 1'b1;
      end
      if (t == 13) start = 1'b0;
      if (done === 1'b1) begin
        pulses++;
        done_cyc = t;
        chk("ign_S", 64'(S), 64'h30);
      end
      @(negedge clk);
    end
    chk("ign_pulses", 64'(pulses), 64'd1);
    chk("ign_done_cycle", 64'(done_cyc), 64'd32);
    chk("ign_idle", 64'(busy), 64'd0);

    // Reset mid-RUN aborts the operation
    A = 32'h1234_5678;
    B = 32'h0000_1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int t = 0; t < 14; t++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_pulses", 64'(pulses), 64'd0);
    chk("rst_mid_S", 64'(S), 64'd0);
    chk("rst_mid_flags", 64'({Cout, Ovf, busy, done}), 64'd0);
    rst = 1'b0;
    run_op("rst_new", 32'h1, 32'h1, 1'b0, 32'h2, 1'b0, 1'b0);

    // Back-to-back with start held high; operands change every cycle
    pulses = 0;
    last_t = -1;
    for (int t = 0; t < 106; t++) begin
      if (done === 1'b1) begin
        pulses++;
        if (last_t < 0) chk("b2b_first", 64'(t), 64'd33);
        else chk("b2b_interval", 64'(t - last_t), 64'd34);
        last_t = t;
        if (t >= 33) begin
          ref_model(ha[t-33], hb[t-33], hc[t-33], rs, rc, ro);
          chk("b2b_S", 64'(S), 64'(rs));
          chk("b2b_flags", 64'({Cout, Ovf}), 64'({rc, ro}));
        end
      end
      ha[t] = $urandom;
      hb[t] = $urandom;
      hc[t] = 1'($urandom);
      A = ha[t];
      B = hb[t];
      Cin = hc[t];
      start = 1'b1;
      @(negedge clk);
    end
    start = 1'b0;
    chk("b2b_pulses", 64'(pulses), 64'd3);
    repeat (40) @(negedge clk);
    chk("b2b_end_idle", 64'({busy, done}), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
